// File: rtl/stage2_decode_sb_if.sv
// Decode-stage instruction/control types and the fetch/writeback/execute handshake bundle.
// The slave modport is the decode stage; the master modport is its environment.
package stage2_decode_sb_pkg;
   typedef logic [31:0] inst_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src_imm;
      logic       rf_rw_en;
      logic       mem_rd;
      logic       mem_wr;
      logic       branch;
      logic       jump;
      logic       rs1_used;
      logic       rs2_used;
      logic       illegal;
   } ctrl_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
endpackage

interface stage2_decode_sb_if #(
   parameter int XLEN   = 32,
   parameter int NUM_WB = 2
) ();
   logic                                in_valid_i;
   logic                                in_ready_o;
   stage2_decode_sb_pkg::inst_t         inst_i;
   logic [XLEN-1:0]                     pc_i;
   logic                                flush_i;
   logic [NUM_WB-1:0]                   wb_en_i;
   logic [NUM_WB-1:0][4:0]              wb_addr_i;
   logic [NUM_WB-1:0][XLEN-1:0]         wb_data_i;
   logic                                out_valid_o;
   logic                                out_ready_i;
   logic [XLEN-1:0]                     out_pc_o;
   logic [XLEN-1:0]                     r1_data_o;
   logic [XLEN-1:0]                     r2_data_o;
   logic [XLEN-1:0]                     imm_o;
   logic [4:0]                          rd_addr_o;
   stage2_decode_sb_pkg::ctrl_t         ctrl_o;

   modport slave (
      input  in_valid_i, inst_i, pc_i, flush_i, wb_en_i, wb_addr_i, wb_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_pc_o, r1_data_o, r2_data_o, imm_o, rd_addr_o, ctrl_o
   );

   modport master (
      output in_valid_i, inst_i, pc_i, flush_i, wb_en_i, wb_addr_i, wb_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_pc_o, r1_data_o, r2_data_o, imm_o, rd_addr_o, ctrl_o
   );
endinterface

// File: rtl/stage2_decode_sb.sv
// Decode stage: register file with write-through bypass, decode and a registered output slot.
// Define TCORE_DECODE_SCOREBOARD_EN to add the busy-bit scoreboard and RAW/WAW stall.
module stage2_decode_sb
   import stage2_decode_sb_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_WB   = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   stage2_decode_sb_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);

   function automatic ctrl_t control_unit(inst_t i);
      ctrl_t c;
      c = '0;
      case (i[6:0])
         OPC_OP:     begin c.rf_rw_en = 1'b1; c.rs1_used = 1'b1; c.rs2_used = 1'b1;
                           c.alu_op = {i[30], i[14:12]}; end
         OPC_OPIMM:  begin c.rf_rw_en = 1'b1; c.rs1_used = 1'b1; c.alu_src_imm = 1'b1;
                           c.alu_op = {(i[14:12] == 3'b101) & i[30], i[14:12]}; end
         OPC_LOAD:   begin c.rf_rw_en = 1'b1; c.rs1_used = 1'b1; c.alu_src_imm = 1'b1;
                           c.mem_rd = 1'b1; end
         OPC_STORE:  begin c.rs1_used = 1'b1; c.rs2_used = 1'b1; c.alu_src_imm = 1'b1;
                           c.mem_wr = 1'b1; end
         OPC_BRANCH: begin c.rs1_used = 1'b1; c.rs2_used = 1'b1; c.branch = 1'b1;
                           c.alu_op = {1'b0, i[14:12]}; end
         OPC_JAL:    begin c.rf_rw_en = 1'b1; c.jump = 1'b1; end
         OPC_JALR:   begin c.rf_rw_en = 1'b1; c.rs1_used = 1'b1; c.jump = 1'b1;
                           c.alu_src_imm = 1'b1; end
         OPC_LUI,
         OPC_AUIPC:  begin c.rf_rw_en = 1'b1; c.alu_src_imm = 1'b1; end
         default:    c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   function automatic logic signed [31:0] extend(inst_t i);
      logic signed [31:0] v;
      case (i[6:0])
         OPC_OPIMM, OPC_LOAD, OPC_JALR: v = {{20{i[31]}}, i[31:20]};
         OPC_STORE:  v = {{20{i[31]}}, i[31:25], i[11:7]};
         OPC_BRANCH: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: v = {i[31:12], 12'b0};
         OPC_JAL:    v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default:    v = '0;
      endcase
      return v;
   endfunction

   // RV32E drops address bit 4 by truncating to AW bits.
   function automatic logic [AW-1:0] reg_idx(logic [4:0] a);
      return a[AW-1:0];
   endfunction

   inst_t                   inst;
   logic [AW-1:0]           rs1, rs2, rd;
   ctrl_t                   ctrl_d;
   logic signed [XLEN-1:0]  imm_d;
   logic [XLEN-1:0]         op1, op2;
   logic [NUM_REGS-1:0]     wb_clr;
   logic                    hazard, accept;
   logic [XLEN-1:0]         rf [NUM_REGS];

   logic                    vld_p1;
   logic [XLEN-1:0]         pc_p1, r1_p1, r2_p1;
   logic signed [XLEN-1:0]  imm_p1;
   logic [4:0]              rd_p1;
   ctrl_t                   ctrl_p1;

   assign inst   = bus.inst_i;
   assign rs1    = reg_idx(inst[19:15]);
   assign rs2    = reg_idx(inst[24:20]);
   assign rd     = reg_idx(inst[11:7]);
   assign ctrl_d = control_unit(inst);
   assign imm_d  = extend(inst);

   always_comb begin
      op1    = (rs1 == '0) ? '0 : rf[rs1];
      op2    = (rs2 == '0) ? '0 : rf[rs2];
      wb_clr = '0;
      for (int k = 0; k < NUM_WB; k++) begin
         if (bus.wb_en_i[k]) begin
            wb_clr[reg_idx(bus.wb_addr_i[k])] = 1'b1;
            if (reg_idx(bus.wb_addr_i[k]) == rs1 && rs1 != '0) op1 = bus.wb_data_i[k];
            if (reg_idx(bus.wb_addr_i[k]) == rs2 && rs2 != '0) op2 = bus.wb_data_i[k];
         end
      end
      wb_clr[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
      end else begin
         for (int k = 0; k < NUM_WB; k++) begin
            if (bus.wb_en_i[k] && reg_idx(bus.wb_addr_i[k]) != '0)
               rf[reg_idx(bus.wb_addr_i[k])] <= bus.wb_data_i[k];
         end
      end
   end

`ifdef TCORE_DECODE_SCOREBOARD_EN
   logic [NUM_REGS-1:0] busy, busy_eff, busy_nxt;
   logic                set_d, set_p1;

   assign set_d    = ctrl_d.rf_rw_en && (rd != '0);
   assign busy_eff = busy & ~wb_clr;
   assign hazard   = (ctrl_d.rs1_used && busy_eff[rs1]) ||
                     (ctrl_d.rs2_used && busy_eff[rs2]) ||
                     (set_d && busy_eff[rd]);

   // A killed entry never writes back, so it must release the bit it claimed.
   always_comb begin
      busy_nxt = busy_eff;
      if (bus.flush_i && vld_p1 && set_p1) busy_nxt[reg_idx(rd_p1)] = 1'b0;
      if (accept && set_d) busy_nxt[rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         busy   <= '0;
         set_p1 <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (accept) set_p1 <= set_d;
      end
   end
`else
   assign hazard = 1'b0;
`endif

   assign bus.in_ready_o = (!vld_p1 || bus.out_ready_i) && !hazard && !bus.flush_i;
   assign accept         = bus.in_valid_i && bus.in_ready_o;

   // ---- stage boundary: decode -> output register ----
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_p1  <= 1'b0;
         pc_p1   <= '0;
         r1_p1   <= '0;
         r2_p1   <= '0;
         imm_p1  <= '0;
         rd_p1   <= '0;
         ctrl_p1 <= '0;
      end else if (bus.flush_i) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         pc_p1   <= bus.pc_i;
         r1_p1   <= op1;
         r2_p1   <= op2;
         imm_p1  <= imm_d;
         rd_p1   <= inst[11:7];
         ctrl_p1 <= ctrl_d;
      end else if (bus.out_ready_i) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.out_valid_o = vld_p1;
   assign bus.out_pc_o    = pc_p1;
   assign bus.r1_data_o   = r1_p1;
   assign bus.r2_data_o   = r2_p1;
   assign bus.imm_o       = imm_p1;
   assign bus.rd_addr_o   = rd_p1;
   assign bus.ctrl_o      = ctrl_p1;
endmodule
